// File: rtl/rbus_out_pktbuf.sv
// rbus_out_pktbuf: two-class store-and-forward packet buffer for one rbus channel.
// Incoming words are queued per class. Upstream flow control comes from reserved space.
// Only complete packets are re-emitted, each as a contiguous burst.
module rbus_out_pktbuf #(
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned LONG_LEN = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_stb,
   input  logic        i_sof,
   input  logic [71:0] i_data,
   output logic [1:0]  i_rdy,
   output logic [1:0]  i_rdyE,
   output logic        o_stb,
   output logic        o_sof,
   output logic [71:0] o_data,
   input  logic [1:0]  o_rdy,
   input  logic [1:0]  o_rdyE,
   output logic        ff_err
);

   localparam int unsigned DW = 72;
   localparam int unsigned MW = DW + 1;
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned LW = 4;

   typedef enum logic {IN_IDLE, IN_PKT} in_state_t;
   typedef enum logic {OUT_IDLE, OUT_SEND} out_state_t;

   // Storage: {sof, data} per word, one FIFO per class
   logic [MW-1:0] mem [2][DEPTH];
   logic [PW-1:0] wr_ptr [2];
   logic [PW-1:0] rd_ptr [2];
   logic [CW-1:0] free   [2];
   logic [CW-1:0] pkts   [2];

   in_state_t     in_state;
   logic [LW-1:0] remain;
   logic          cls;
   logic          discard;

   out_state_t    out_state;
   logic          out_cls;
   logic [LW-1:0] out_cnt;
   logic          last_cls;

   logic          hdr_cls;
   logic          hdr_long;
   logic          wr_en;
   logic          wr_c;
   logic          err;
   logic [CW-1:0] rsv [2];
   logic [1:0]    cmp;
   logic [1:0]    elig;
   logic          sel;
   logic          pick;
   logic [1:0]    pick_dec;
   logic          rd_en;
   logic [1:0]    rd_cred;
   logic [MW-1:0] rd_word;
   logic          rd_last;
   logic          unused_rdye;

   // Consumer-empty status is informational only
   assign unused_rdye = ^o_rdyE;

   // Flow control straight from the reservation counters
   assign i_rdy[0]  = (free[0] >= CW'(LONG_LEN));
   assign i_rdy[1]  = (free[1] >= CW'(LONG_LEN));
   assign i_rdyE[0] = (free[0] == CW'(DEPTH));
   assign i_rdyE[1] = (free[1] == CW'(DEPTH));

   // Input decode: write enable, reservation, packet completion, protocol errors
   always_comb begin
      hdr_cls  = i_data[DW-1];
      hdr_long = i_data[DW-2];
      wr_en    = 1'b0;
      wr_c     = cls;
      err      = 1'b0;
      rsv[0]   = '0;
      rsv[1]   = '0;
      cmp      = 2'b00;
      if (i_stb) begin
         if (in_state == IN_IDLE) begin
            if (!i_sof || !i_rdy[hdr_cls]) begin
               err = 1'b1;
            end else begin
               wr_en        = 1'b1;
               wr_c         = hdr_cls;
               rsv[hdr_cls] = hdr_long ? CW'(LONG_LEN) : CW'(1);
               cmp[hdr_cls] = !hdr_long;
            end
         end else begin
            if (i_sof) begin
               err = 1'b1;
            end else if (!discard) begin
               wr_en    = 1'b1;
               cmp[cls] = (remain == LW'(1));
            end
         end
      end
   end

   // Output decode: round-robin selection and read of the current word
   always_comb begin
      elig     = {(pkts[1] != '0) & o_rdy[1], (pkts[0] != '0) & o_rdy[0]};
      sel      = (elig == 2'b11) ? !last_cls : elig[1];
      pick     = (out_state == OUT_IDLE) && (elig != 2'b00);
      pick_dec = pick ? (sel ? 2'b10 : 2'b01) : 2'b00;
      rd_en    = (out_state == OUT_SEND);
      rd_cred  = rd_en ? (out_cls ? 2'b10 : 2'b01) : 2'b00;
      rd_word  = mem[out_cls][rd_ptr[out_cls]];
      rd_last  = (out_cnt == '0) ? !rd_word[DW-2] : (out_cnt == LW'(LONG_LEN - 1));
   end

   // FIFO storage write (no reset needed on the array)
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_c][wr_ptr[wr_c]] <= {i_sof, i_data};
   end

   // Pointers and per-class counters; read credit and reservation merge in one update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < 2; c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
            free[c]   <= CW'(DEPTH);
            pkts[c]   <= '0;
         end
      end else begin
         if (wr_en) wr_ptr[wr_c] <= wr_ptr[wr_c] + PW'(1);
         if (rd_en) rd_ptr[out_cls] <= rd_ptr[out_cls] + PW'(1);
         for (int c = 0; c < 2; c++) begin
            free[c] <= free[c] + CW'(rd_cred[c]) - rsv[c];
            pkts[c] <= pkts[c] + CW'(cmp[c]) - CW'(pick_dec[c]);
         end
      end
   end

   // Input FSM: packet framing, discard mode and sticky error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_state <= IN_IDLE;
         remain   <= '0;
         cls      <= 1'b0;
         discard  <= 1'b0;
         ff_err   <= 1'b0;
      end else begin
         if (err) ff_err <= 1'b1;
         if (i_stb) begin
            case (in_state)
               IN_IDLE: begin
                  if (i_sof && hdr_long) begin
                     in_state <= IN_PKT;
                     remain   <= LW'(LONG_LEN - 1);
                     cls      <= hdr_cls;
                     discard  <= !i_rdy[hdr_cls];
                  end
               end
               IN_PKT: begin
                  if (!i_sof) begin
                     remain <= remain - LW'(1);
                     if (remain == LW'(1)) in_state <= IN_IDLE;
                  end
               end
               default: in_state <= IN_IDLE;
            endcase
         end
      end
   end

   // Output FSM: select a complete packet, then stream it without stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_state <= OUT_IDLE;
         out_cls   <= 1'b0;
         out_cnt   <= '0;
         last_cls  <= 1'b1;
         o_stb     <= 1'b0;
         o_sof     <= 1'b0;
         o_data    <= '0;
      end else begin
         case (out_state)
            OUT_IDLE: begin
               o_stb <= 1'b0;
               o_sof <= 1'b0;
               if (pick) begin
                  out_state <= OUT_SEND;
                  out_cls   <= sel;
                  out_cnt   <= '0;
               end
            end
            OUT_SEND: begin
               o_stb   <= 1'b1;
               o_sof   <= rd_word[MW-1];
               o_data  <= rd_word[DW-1:0];
               out_cnt <= out_cnt + LW'(1);
               if (rd_last) begin
                  out_state <= OUT_IDLE;
                  last_cls  <= out_cls;
               end
            end
            default: out_state <= OUT_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rbus_out_pktbuf.sv
// tb_rbus_out_pktbuf: directed bench with an output scoreboard for rbus_out_pktbuf.
module tb_rbus_out_pktbuf;

   logic        clk;
   logic        rst;
   logic        i_stb;
   logic        i_sof;
   logic [71:0] i_data;
   logic [1:0]  i_rdy;
   logic [1:0]  i_rdyE;
   logic        o_stb;
   logic        o_sof;
   logic [71:0] o_data;
   logic [1:0]  o_rdy;
   logic [1:0]  o_rdyE;
   logic        ff_err;

   int n_chk  = 0;
   int n_fail = 0;
   logic [72:0] exp_q[$];
   logic        prev_stb = 1'b0;

   rbus_out_pktbuf #(.DEPTH(32), .LONG_LEN(9)) dut (
      .clk(clk), .rst(rst),
      .i_stb(i_stb), .i_sof(i_sof), .i_data(i_data),
      .i_rdy(i_rdy), .i_rdyE(i_rdyE),
      .o_stb(o_stb), .o_sof(o_sof), .o_data(o_data),
      .o_rdy(o_rdy), .o_rdyE(o_rdyE),
      .ff_err(ff_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every presented output word must match the queue head
   always @(negedge clk) begin
      if (!rst && o_stb) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL out_word: got %h required nothing", {o_sof, o_data});
         end else begin
            logic [72:0] e;
            e = exp_q.pop_front();
            if ({o_sof, o_data} !== e) begin
               n_fail++;
               $display("FAIL out_word: got %h required %h", {o_sof, o_data}, e);
            end
         end
         if (o_sof) begin
            n_chk++;
            if (prev_stb) begin
               n_fail++;
               $display("FAIL out_gap: got prev_stb=1 required 0");
            end
         end
      end
      prev_stb = o_stb;
   end

   function automatic logic [71:0] hdr(input logic c, input logic lng, input int tag);
      return {c, lng, 70'(tag)};
   endfunction

   function automatic logic [71:0] pay(input int tag);
      return {2'b00, 70'(tag)};
   endfunction

   task automatic send_word(input logic sof, input logic [71:0] d);
      i_stb  = 1'b1;
      i_sof  = sof;
      i_data = d;
      @(posedge clk);
      #1;
      i_stb  = 1'b0;
      i_sof  = 1'b0;
   endtask

   task automatic send_pkt(input logic c, input logic lng, input int tag, input bit push);
      if (push) exp_q.push_back({1'b1, hdr(c, lng, tag)});
      send_word(1'b1, hdr(c, lng, tag));
      if (lng) begin
         for (int k = 1; k < 9; k++) begin
            if (push) exp_q.push_back({1'b0, pay(tag + k)});
            send_word(1'b0, pay(tag + k));
         end
      end
   endtask

   // Called right after the last input word edge t: first output must appear at t+2
   task automatic check_latency(input string name);
      check({name, "_lat_t"}, 73'(o_stb), 73'(0));
      @(posedge clk); #1;
      check({name, "_lat_t1"}, 73'(o_stb), 73'(0));
      @(posedge clk); #1;
      check({name, "_lat_t2"}, 73'({o_stb, o_sof}), 73'(2'b11));
   endtask

   task automatic wait_drain(input string name);
      bit done;
      done = 1'b0;
      for (int n = 0; n < 300 && !done; n++) begin
         @(posedge clk); #1;
         if (exp_q.size() == 0 && !o_stb) done = 1'b1;
      end
      check({name, "_drained"}, 73'(done), 73'(1));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int k;
      rst    = 1'b1;
      i_stb  = 1'b0;
      i_sof  = 1'b0;
      i_data = '0;
      o_rdy  = 2'b00;
      o_rdyE = 2'b11;
      repeat (2) @(posedge clk);
      #1;
      check("rst_o_stb",  73'({o_stb, o_sof}), 73'(0));
      check("rst_o_data", 73'(o_data), 73'(0));
      check("rst_i_rdy",  73'(i_rdy),  73'(2'b11));
      check("rst_i_rdyE", 73'(i_rdyE), 73'(2'b11));
      check("rst_ff_err", 73'(ff_err), 73'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Round-robin: two short packets per class, output order 0,1,0,1
      o_rdy = 2'b00;
      exp_q.push_back({1'b1, hdr(0, 0, 16'h0A0)});
      exp_q.push_back({1'b1, hdr(1, 0, 16'h1C0)});
      exp_q.push_back({1'b1, hdr(0, 0, 16'h0B0)});
      exp_q.push_back({1'b1, hdr(1, 0, 16'h1D0)});
      send_pkt(0, 0, 16'h0A0, 0);
      send_pkt(0, 0, 16'h0B0, 0);
      send_pkt(1, 0, 16'h1C0, 0);
      send_pkt(1, 0, 16'h1D0, 0);
      check("rr_i_rdyE_held", 73'(i_rdyE), 73'(2'b00));
      o_rdy = 2'b11;
      wait_drain("rr");

      // Single long packet on class 0, back-to-back input
      exp_q.push_back({1'b1, hdr(0, 1, 16'h200)});
      send_word(1'b1, hdr(0, 1, 16'h200));
      check("long_i_rdyE", 73'(i_rdyE), 73'(2'b10));
      check("long_i_rdy",  73'(i_rdy),  73'(2'b11));
      for (int j = 1; j < 9; j++) begin
         exp_q.push_back({1'b0, pay(16'h200 + j)});
         send_word(1'b0, pay(16'h200 + j));
      end
      check_latency("long");
      wait_drain("long");
      check("long_i_rdyE_back", 73'(i_rdyE), 73'(2'b11));

      // Fill class 1 to threshold, then an over-subscribed header is dropped
      o_rdy = 2'b00;
      send_pkt(1, 1, 16'h300, 1);
      send_pkt(1, 1, 16'h310, 1);
      check("fill_i_rdy_2", 73'(i_rdy), 73'(2'b11));
      send_pkt(1, 1, 16'h320, 1);
      check("fill_i_rdy_3", 73'(i_rdy), 73'(2'b01));
      check("fill_ff_err0", 73'(ff_err), 73'(0));
      send_pkt(1, 1, 16'h330, 0);
      check("drop_ff_err", 73'(ff_err), 73'(1));
      check("drop_i_rdy",  73'(i_rdy),  73'(2'b01));
      o_rdy = 2'b10;
      wait_drain("fill");
      check("fill_i_rdy_back",  73'(i_rdy),  73'(2'b11));
      check("fill_i_rdyE_back", 73'(i_rdyE), 73'(2'b11));

      // Stray non-sof word while idle
      do_reset();
      check("stray_ff_err0", 73'(ff_err), 73'(0));
      o_rdy = 2'b11;
      send_word(1'b0, pay(16'h400));
      check("stray_ff_err", 73'(ff_err), 73'(1));
      send_pkt(1, 0, 16'h410, 1);
      wait_drain("stray");

      // Sof inside a long packet is dropped, original packet intact
      do_reset();
      check("sofin_ff_err0", 73'(ff_err), 73'(0));
      exp_q.push_back({1'b1, hdr(0, 1, 16'h500)});
      send_word(1'b1, hdr(0, 1, 16'h500));
      for (int j = 1; j < 9; j++) begin
         exp_q.push_back({1'b0, pay(16'h500 + j)});
         send_word(1'b0, pay(16'h500 + j));
         if (j == 3) send_word(1'b1, hdr(1, 0, 16'h5FF));
      end
      check("sofin_ff_err", 73'(ff_err), 73'(1));
      wait_drain("sofin");

      // Reset during output word 4 of a long packet
      send_pkt(0, 1, 16'h600, 1);
      k = 0;
      for (int n = 0; n < 60 && k < 4; n++) begin
         @(posedge clk); #1;
         if (o_stb) k++;
      end
      check("mid_reached_word4", 73'(k), 73'(4));
      rst = 1'b1;
      #1;
      check("mid_o_stb",  73'(o_stb),  73'(0));
      check("mid_i_rdy",  73'(i_rdy),  73'(2'b11));
      check("mid_i_rdyE", 73'(i_rdyE), 73'(2'b11));
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      send_pkt(0, 0, 16'h700, 1);
      check_latency("post_rst");
      wait_drain("post_rst");

      check("final_queue_empty", 73'(exp_q.size()), 73'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rbus_out_pktbuf.md
# rbus_out_pktbuf

Two-class store-and-forward packet buffer for one rbus channel. One instance sits directly downstream of each output `o_[m]` of the N-to-M rbus channel mux. It absorbs the mux's bursty output into per-class word FIFOs and drives the upstream `rdy`/`rdyE` flow control from reserved buffer space. It re-emits only complete packets as contiguous bursts toward the channel consumer.

## Interface
- `DEPTH`, 32, words per class FIFO; power of two, minimum 2*`LONG_LEN`.
- `LONG_LEN`, 9, length of a long packet in words (header plus 8 payload words); a short packet is 1 word.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_stb`  in  1  input word valid.
- `i_sof`  in  1  first word (header) of a packet.
- `i_data`  in  72  word; header fields: `[71]` class c, `[70]` long flag (1 = `LONG_LEN` words, 0 = 1 word).
- `i_rdy`  out  2  `i_rdy[c]`: class c can accept a new long packet.
- `i_rdyE`  out  2  `i_rdyE[c]`: class c buffer holds no words and no reservations.
- `o_stb`, `o_sof`  out  1 each  output word valid / first word.
- `o_data`  out  72  output word.
- `o_rdy`  in  2  consumer can take a whole packet of class c.
- `o_rdyE`  in  2  consumer class c empty; informational only, not used.
- `ff_err`  out  1  sticky protocol-error flag.

## Operation
- **Storage:** two FIFOs, one per class, each `DEPTH` x 73 bits (data plus sof). Read and write pointers wrap modulo `DEPTH`.
- **Per-class counters:**
  - `free[c]` (0..`DEPTH`) tracks unreserved words.
  - `pkts[c]` (0..`DEPTH`) counts complete packets stored.
- **Reservation:** on an accepted header, `free[c]` drops by the packet length (1 or `LONG_LEN`) at once. Each word read out adds 1 back.
- **Flow-control outputs:** both are combinational from registers.
  - `i_rdy[c]` = (`free[c]` >= `LONG_LEN`).
  - `i_rdyE[c]` = (`free[c]` == `DEPTH`).
- **Input FSM:** states IN_IDLE and IN_PKT, with `remain` (4 bits) and `cls`.
  - IN_IDLE, `i_stb` & `i_sof` & `i_rdy[class]`: write word, reserve space. A short packet increments `pkts` and stays in IN_IDLE. A long packet loads `remain`=`LONG_LEN`-1 and moves to IN_PKT.
  - IN_PKT, `i_stb` & !`i_sof`: write to FIFO `cls`, decrement `remain`. At `remain`==1, increment `pkts[cls]` and return to IN_IDLE.
  - Idle cycles (`i_stb`=0) inside a packet are allowed.
- **Input error cases:** each sets `ff_err` and drops the word.
  - Header while `i_rdy[class]`=0: the whole packet is dropped. The FSM still enters IN_PKT in discard mode, and no writes occur.
  - `i_stb` & !`i_sof` in IN_IDLE.
  - `i_stb` & `i_sof` in IN_PKT. The FSM keeps counting the current packet.
- **Output FSM:** states OUT_IDLE and OUT_SEND, with a `last_cls` round-robin bit and a word counter.
  - OUT_IDLE: class c is eligible when `pkts[c]`>0 and `o_rdy[c]`=1.
  - If both classes are eligible, choose !`last_cls`.
  - On selection: decrement `pkts[c]`, enter OUT_SEND, and emit the packet words on consecutive cycles with `o_sof` on the first. Length is taken from the stored header `[70]`.
  - After the last word, return to OUT_IDLE and update `last_cls`.
  - `o_rdy` is sampled only at selection; once started, a packet is never stalled.
- **Simultaneous read and write on one class:** `free` is updated by (read credit − reservation) in the same cycle, and `pkts` by (+complete − select). No update is lost.
- **Reset mid-operation:** clears all counters, pointers and FSMs. Stored packets are discarded.

## Timing
- **Reset values:**
  - `o_stb`=0, `o_sof`=0, `o_data`=0.
  - `i_rdy`=2'b11, `i_rdyE`=2'b11.
  - `ff_err`=0.
  - `free`=`DEPTH`, `pkts`=0, both FSMs idle, `last_cls`=1 (class 0 wins the first tie).
- **Output registers:** `o_stb`, `o_sof` and `o_data` are registered.
- **Latency:** last input word at edge t → `pkts` visible after t → selection at t+1 → `o_sof` at t+2.
- **Output gap:** at least one idle cycle between consecutive output packets.
- **Flow-control update:** `i_rdy`/`i_rdyE` reflect a header accepted at edge t from cycle t+1. Upstream may start a class-c packet only in a cycle where `i_rdy[c]`=1.
- **Error flag:** `ff_err` rises one cycle after the offending word and clears only on `rst`.

## Test plan
- **Single long packet:** class 0 long packet, 9 back-to-back words, `o_rdy`=11 → 9 contiguous output words, `o_sof` on the first, first output 2 cycles after the last input. `i_rdyE[0]`=0 from the cycle after the header until the last word leaves.
- **Fill to threshold:** `DEPTH`=32, `o_rdy`=00; send three long class-1 packets → `i_rdy[1]` falls after the 3rd header (free=5). `i_rdy[0]` stays 1. Raise `o_rdy[1]` → 3 packets drain and `i_rdy[1]` returns to 1.
- **Round-robin:** with both classes holding 2 short packets and `o_rdy`=11 → output class order 0,1,0,1 with one gap cycle between packets.
- **Protocol errors:**
  - Header with `i_rdy[c]`=0 → `ff_err`=1, packet absent from output.
  - Stray non-sof word in IN_IDLE → `ff_err` set, word dropped.
  - Sof inside a long packet → `ff_err` set, original packet still output with 9 words.
- **Reset mid-stream:** assert `rst` during output word 4 of a long packet → `o_stb`=0 immediately, `i_rdy`=11, `i_rdyE`=11. A subsequent short packet passes with normal latency.
